alu_issue_decoder: RTL and testbench
====================================

Name: alu_issue_decoder

Overview:
Producer side of the ALU operand/funct interface. Decodes a MIPS instruction plus register-file operands into the ALU's 5-bit funct code, alu_src, immediate and operand pair, then registers them into the ID/EX slot. Provides a valid/ready handshake with a 2-entry skid buffer, and is flushed when the ALU asserts a PC change. Sits between register read and the combinational ALU, one instance per issue lane.

Parameters:
- DWIDTH, 32, datapath width (header value).
- PC_WIDTH, 32, PC width (header value).
- IMM_WIDTH, 16, immediate width (header value).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- d_i_valid  in  1  upstream instruction valid
- d_o_ready  out  1  upstream may transfer
- d_i_instr  in  32  instruction word
- d_i_pc  in  PC_WIDTH  instruction PC
- d_i_data_rs  in  DWIDTH  register-file value of rs
- d_i_data_rt  in  DWIDTH  register-file value of rt
- d_i_flush  in  1  redirect from the ALU's change-PC output
- d_o_valid  out  1  ID/EX slot valid
- d_i_ready  in  1  execute stage accepts
- d_o_funct  out  5  ALU funct code
- d_o_alu_src  out  1  1 selects the immediate as operand 2
- d_o_imm  out  IMM_WIDTH  immediate to the ALU
- d_o_data_rs  out  DWIDTH  ALU operand 1
- d_o_data_rt  out  DWIDTH  ALU operand 2 (register path)
- d_o_pc  out  PC_WIDTH  PC of the slot
- d_o_rd  out  5  destination register
- d_o_reg_write  out  1  result written back
- d_o_is_branch  out  1  beq/bne
- d_o_mem  out  2  00 none, 01 load, 10 store
- d_o_illegal  out  1  undecodable instruction

Behaviour:
- Reset (asynchronous, i_rst_n low): both buffer entries are invalid. All outputs are 0 except d_o_ready, which is 1.
- Funct codes (fixed): add 0, sub 1, and 2, or 3, nor 4, slt 5, sltu 6, sll 7, srl 8, sra 9, eq 10, neq 11, ge 12, geu 13, addu 14, subu 17, lui 18, jr 19.
- R-type (op 0), by funct field:
  - 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu: rs/rt operands, alu_src=0, rd=instr[15:11], reg_write=1.
  - 0x24 and, 0x25 or, 0x27 nor, 0x2A slt, 0x2B sltu: same operand, rd and reg_write rules.
  - sll 0x00, srl 0x02, sra 0x03: operand 1 = rt value, alu_src=1, imm={11'b0, shamt}.
  - sllv 0x04, srlv 0x06, srav 0x07: operand 1 = rt value, operand 2 = rs value, alu_src=0.
  - jr 0x08: funct 19, reg_write=0.
- I-type: rd=instr[20:16], reg_write=1, alu_src=1, imm sign-extended by the ALU.
  - addi 0x08 add; addiu 0x09 addu; slti 0x0A slt; sltiu 0x0B sltu; lui 0x0F lui.
  - lw 0x23 add with mem=01; sw 0x2B add with mem=10 and reg_write=0.
  - andi 0x0C and ori 0x0D: alu_src=0, operand 2 = zero-extended imm. This is required because the ALU sign-extends.
  - beq 0x04 eq and bne 0x05 neq: operands rs/rt, alu_src=0, is_branch=1, reg_write=0.
- Any other encoding: illegal=1, funct=0, reg_write=0, mem=00. It is still passed downstream.
- Handshake:
  - Upstream transfer occurs when d_i_valid && d_o_ready; downstream transfer when d_o_valid && d_i_ready.
  - Decode is combinational; the decoded bundle is registered, giving 1-cycle latency from transfer to d_o_valid.
  - 2-entry FIFO (main + skid). d_o_ready is registered and equals (count < 2) after the update; it must not depend combinationally on d_i_ready.
  - Simultaneous push and pop with count=2: pop happens, push is blocked because ready was low.
  - Simultaneous push and pop with count=1: count stays 1 and the output advances to the new entry.
  - Outputs hold stable while d_o_valid && !d_i_ready.
- Flush: d_i_flush high at a clock edge invalidates both entries and drops any same-cycle upstream push. Next cycle: d_o_valid=0, d_o_ready=1. Flush has priority over push and pop.
- Reset asserted mid-transfer: state clears immediately with no partial bundle.

Decomposition:
- Shared header holds funct code constants (FUNCT_ADD..FUNCT_JR), opcode and R-funct constants, and MEM_NONE/LOAD/STORE.
- One combinational sub-module, mips_alu_ctrl: instruction and operands in, decoded bundle out.
- The top module holds the 2-entry buffer and the handshake.

Test Plan:
- Reset: hold i_rst_n=0, then release → d_o_valid=0, d_o_ready=1, all bundle outputs 0.
- add $3,$1,$2 (0x00221820), rs=5, rt=7, d_i_ready=1 → next cycle valid=1, funct=0, alu_src=0, rd=3, reg_write=1.
- ori $4,$0,0x8001 → alu_src=0, data_rt=0x00008001 (not 0xFFFF8001), funct=3.
- sll $5,$6,4 with rt=0x11 → data_rs=0x11, alu_src=1, imm=4, funct=7. The bench checks that the real ALU output is 0x110.
- Backpressure: d_i_ready=0 while pushing 3 instructions → first two accepted, d_o_ready=0 on the third. Releasing ready drains them in order with no loss or duplication.
- Flush: two entries buffered, d_i_flush=1 with d_i_valid=1 in the same cycle → next cycle valid=0, ready=1. Flushed instructions never appear on the output.

Source files
------------

// File: rtl/alu_issue_decoder_pkg.sv
// Shared header for the ALU issue decoder: ALU funct codes, MIPS opcodes and
// R-type funct fields, memory-op encoding and the decoded bundle type.
package alu_issue_decoder_pkg;

    localparam int DWIDTH    = 32;
    localparam int PC_WIDTH  = 32;
    localparam int IMM_WIDTH = 16;

    localparam logic [4:0] FUNCT_ADD  = 5'd0;
    localparam logic [4:0] FUNCT_SUB  = 5'd1;
    localparam logic [4:0] FUNCT_AND  = 5'd2;
    localparam logic [4:0] FUNCT_OR   = 5'd3;
    localparam logic [4:0] FUNCT_NOR  = 5'd4;
    localparam logic [4:0] FUNCT_SLT  = 5'd5;
    localparam logic [4:0] FUNCT_SLTU = 5'd6;
    localparam logic [4:0] FUNCT_SLL  = 5'd7;
    localparam logic [4:0] FUNCT_SRL  = 5'd8;
    localparam logic [4:0] FUNCT_SRA  = 5'd9;
    localparam logic [4:0] FUNCT_EQ   = 5'd10;
    localparam logic [4:0] FUNCT_NEQ  = 5'd11;
    localparam logic [4:0] FUNCT_GE   = 5'd12;
    localparam logic [4:0] FUNCT_GEU  = 5'd13;
    localparam logic [4:0] FUNCT_ADDU = 5'd14;
    localparam logic [4:0] FUNCT_SUBU = 5'd17;
    localparam logic [4:0] FUNCT_LUI  = 5'd18;
    localparam logic [4:0] FUNCT_JR   = 5'd19;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] RF_SLL  = 6'h00;
    localparam logic [5:0] RF_SRL  = 6'h02;
    localparam logic [5:0] RF_SRA  = 6'h03;
    localparam logic [5:0] RF_SLLV = 6'h04;
    localparam logic [5:0] RF_SRLV = 6'h06;
    localparam logic [5:0] RF_SRAV = 6'h07;
    localparam logic [5:0] RF_JR   = 6'h08;
    localparam logic [5:0] RF_ADD  = 6'h20;
    localparam logic [5:0] RF_ADDU = 6'h21;
    localparam logic [5:0] RF_SUB  = 6'h22;
    localparam logic [5:0] RF_SUBU = 6'h23;
    localparam logic [5:0] RF_AND  = 6'h24;
    localparam logic [5:0] RF_OR   = 6'h25;
    localparam logic [5:0] RF_NOR  = 6'h27;
    localparam logic [5:0] RF_SLT  = 6'h2A;
    localparam logic [5:0] RF_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } mem_e;

    typedef struct packed {
        logic [4:0]           funct;
        logic                 alu_src;
        logic [IMM_WIDTH-1:0] imm;
        logic [DWIDTH-1:0]    data_rs;
        logic [DWIDTH-1:0]    data_rt;
        logic [PC_WIDTH-1:0]  pc;
        logic [4:0]           rd;
        logic                 reg_write;
        logic                 is_branch;
        mem_e                 mem;
        logic                 illegal;
    } issue_bundle_t;

endpackage

// File: rtl/alu_issue_decoder_if.sv
// Upstream/downstream handshake and decoded ALU bundle of one issue lane.
interface alu_issue_decoder_if;
    import alu_issue_decoder_pkg::*;

    logic                 d_i_valid;
    logic                 d_o_ready;
    logic [31:0]          d_i_instr;
    logic [PC_WIDTH-1:0]  d_i_pc;
    logic [DWIDTH-1:0]    d_i_data_rs;
    logic [DWIDTH-1:0]    d_i_data_rt;
    logic                 d_i_flush;
    logic                 d_o_valid;
    logic                 d_i_ready;
    logic [4:0]           d_o_funct;
    logic                 d_o_alu_src;
    logic [IMM_WIDTH-1:0] d_o_imm;
    logic [DWIDTH-1:0]    d_o_data_rs;
    logic [DWIDTH-1:0]    d_o_data_rt;
    logic [PC_WIDTH-1:0]  d_o_pc;
    logic [4:0]           d_o_rd;
    logic                 d_o_reg_write;
    logic                 d_o_is_branch;
    logic [1:0]           d_o_mem;
    logic                 d_o_illegal;

    modport master (
        input  d_i_valid, d_i_instr, d_i_pc, d_i_data_rs, d_i_data_rt, d_i_flush, d_i_ready,
        output d_o_ready, d_o_valid, d_o_funct, d_o_alu_src, d_o_imm, d_o_data_rs,
               d_o_data_rt, d_o_pc, d_o_rd, d_o_reg_write, d_o_is_branch, d_o_mem, d_o_illegal
    );

    modport slave (
        output d_i_valid, d_i_instr, d_i_pc, d_i_data_rs, d_i_data_rt, d_i_flush, d_i_ready,
        input  d_o_ready, d_o_valid, d_o_funct, d_o_alu_src, d_o_imm, d_o_data_rs,
               d_o_data_rt, d_o_pc, d_o_rd, d_o_reg_write, d_o_is_branch, d_o_mem, d_o_illegal
    );

endinterface

// File: rtl/alu_issue_decoder_mips_alu_ctrl.sv
// Combinational MIPS decode: instruction plus register operands in, ALU bundle out.
module mips_alu_ctrl
    import alu_issue_decoder_pkg::*;
(
    input  logic [31:0]         i_instr,
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic [DWIDTH-1:0]   i_data_rs,
    input  logic [DWIDTH-1:0]   i_data_rt,
    output issue_bundle_t       o_bundle
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_ill;
    logic       w_sh_imm;
    logic       w_sh_var;
    logic [4:0] w_unused_rs_field;

    assign w_op = i_instr[31:26];
    assign w_fn = i_instr[5:0];
    assign w_unused_rs_field = i_instr[25:21];

    always_comb begin
        o_bundle         = '0;
        o_bundle.pc      = i_pc;
        o_bundle.data_rs = i_data_rs;
        o_bundle.data_rt = i_data_rt;
        o_bundle.imm     = i_instr[15:0];
        w_ill            = 1'b0;
        w_sh_imm         = 1'b0;
        w_sh_var         = 1'b0;
        if (w_op == OP_RTYPE) begin
            o_bundle.rd        = i_instr[15:11];
            o_bundle.reg_write = 1'b1;
            case (w_fn)
                RF_ADD:  o_bundle.funct = FUNCT_ADD;
                RF_ADDU: o_bundle.funct = FUNCT_ADDU;
                RF_SUB:  o_bundle.funct = FUNCT_SUB;
                RF_SUBU: o_bundle.funct = FUNCT_SUBU;
                RF_AND:  o_bundle.funct = FUNCT_AND;
                RF_OR:   o_bundle.funct = FUNCT_OR;
                RF_NOR:  o_bundle.funct = FUNCT_NOR;
                RF_SLT:  o_bundle.funct = FUNCT_SLT;
                RF_SLTU: o_bundle.funct = FUNCT_SLTU;
                RF_SLL:  begin o_bundle.funct = FUNCT_SLL; w_sh_imm = 1'b1; end
                RF_SRL:  begin o_bundle.funct = FUNCT_SRL; w_sh_imm = 1'b1; end
                RF_SRA:  begin o_bundle.funct = FUNCT_SRA; w_sh_imm = 1'b1; end
                RF_SLLV: begin o_bundle.funct = FUNCT_SLL; w_sh_var = 1'b1; end
                RF_SRLV: begin o_bundle.funct = FUNCT_SRL; w_sh_var = 1'b1; end
                RF_SRAV: begin o_bundle.funct = FUNCT_SRA; w_sh_var = 1'b1; end
                RF_JR:   begin o_bundle.funct = FUNCT_JR; o_bundle.reg_write = 1'b0; end
                default: w_ill = 1'b1;
            endcase
            // Shifts move the shifted value (rt) onto operand 1.
            if (w_sh_imm || w_sh_var) o_bundle.data_rs = i_data_rt;
            if (w_sh_var) o_bundle.data_rt = i_data_rs;
            if (w_sh_imm) begin
                o_bundle.alu_src = 1'b1;
                o_bundle.imm     = {{(IMM_WIDTH-5){1'b0}}, i_instr[10:6]};
            end
        end else begin
            o_bundle.rd        = i_instr[20:16];
            o_bundle.reg_write = 1'b1;
            o_bundle.alu_src   = 1'b1;
            case (w_op)
                OP_ADDI:  o_bundle.funct = FUNCT_ADD;
                OP_ADDIU: o_bundle.funct = FUNCT_ADDU;
                OP_SLTI:  o_bundle.funct = FUNCT_SLT;
                OP_SLTIU: o_bundle.funct = FUNCT_SLTU;
                OP_LUI:   o_bundle.funct = FUNCT_LUI;
                OP_LW:    begin o_bundle.funct = FUNCT_ADD; o_bundle.mem = MEM_LOAD; end
                OP_SW:    begin
                    o_bundle.funct     = FUNCT_ADD;
                    o_bundle.mem       = MEM_STORE;
                    o_bundle.reg_write = 1'b0;
                end
                // The ALU sign-extends imm, so logical immediates go zero-extended via operand 2.
                OP_ANDI, OP_ORI: begin
                    o_bundle.funct   = (w_op == OP_ANDI) ? FUNCT_AND : FUNCT_OR;
                    o_bundle.alu_src = 1'b0;
                    o_bundle.data_rt = {{(DWIDTH-IMM_WIDTH){1'b0}}, i_instr[15:0]};
                end
                OP_BEQ, OP_BNE: begin
                    o_bundle.funct     = (w_op == OP_BEQ) ? FUNCT_EQ : FUNCT_NEQ;
                    o_bundle.alu_src   = 1'b0;
                    o_bundle.is_branch = 1'b1;
                    o_bundle.reg_write = 1'b0;
                end
                default: w_ill = 1'b1;
            endcase
        end
        if (w_ill) begin
            o_bundle.funct     = FUNCT_ADD;
            o_bundle.alu_src   = 1'b0;
            o_bundle.reg_write = 1'b0;
            o_bundle.is_branch = 1'b0;
            o_bundle.mem       = MEM_NONE;
            o_bundle.illegal   = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_decoder.sv
// ID/EX slot of one issue lane: decode, then a 2-entry (main + skid) buffer
// with a registered ready so upstream never sees downstream ready combinationally.
module alu_issue_decoder
    import alu_issue_decoder_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    alu_issue_decoder_if.master bus
);

    issue_bundle_t w_dec;
    issue_bundle_t r_e0, r_e1, w_e0_nxt, w_e1_nxt;
    logic [1:0]    r_cnt, w_cnt_nxt;
    logic          r_ready;
    logic          w_push, w_pop;

    mips_alu_ctrl u_ctrl (
        .i_instr   (bus.d_i_instr),
        .i_pc      (bus.d_i_pc),
        .i_data_rs (bus.d_i_data_rs),
        .i_data_rt (bus.d_i_data_rt),
        .o_bundle  (w_dec)
    );

    assign w_push = bus.d_i_valid && r_ready;
    assign w_pop  = (r_cnt != 2'd0) && bus.d_i_ready;

    always_comb begin
        w_e0_nxt  = r_e0;
        w_e1_nxt  = r_e1;
        w_cnt_nxt = r_cnt;
        if (bus.d_i_flush) begin
            w_cnt_nxt = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) w_e0_nxt = w_dec;
                    else               w_e1_nxt = w_dec;
                    w_cnt_nxt = r_cnt + 2'd1;
                end
                2'b01: begin
                    w_e0_nxt  = r_e1;
                    w_cnt_nxt = r_cnt - 2'd1;
                end
                // Push with pop implies count==1 (ready was high): the head is replaced.
                2'b11: w_e0_nxt = w_dec;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_cnt   <= 2'd0;
            r_ready <= 1'b1;
        end else begin
            r_e0    <= w_e0_nxt;
            r_e1    <= w_e1_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_cnt_nxt != 2'd2);
        end
    end

    assign bus.d_o_ready     = r_ready;
    assign bus.d_o_valid     = (r_cnt != 2'd0);
    assign bus.d_o_funct     = r_e0.funct;
    assign bus.d_o_alu_src   = r_e0.alu_src;
    assign bus.d_o_imm       = r_e0.imm;
    assign bus.d_o_data_rs   = r_e0.data_rs;
    assign bus.d_o_data_rt   = r_e0.data_rt;
    assign bus.d_o_pc        = r_e0.pc;
    assign bus.d_o_rd        = r_e0.rd;
    assign bus.d_o_reg_write = r_e0.reg_write;
    assign bus.d_o_is_branch = r_e0.is_branch;
    assign bus.d_o_mem       = r_e0.mem;
    assign bus.d_o_illegal   = r_e0.illegal;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Directed bench for alu_issue_decoder: decode vectors, skid-buffer backpressure, flush, reset.
module tb_alu_issue_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vec = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    alu_issue_decoder_if bus();

    alu_issue_decoder dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] instr;
        logic [31:0] ds, dt;
        logic [4:0]  funct;
        logic        src;
        logic [4:0]  rd;
        logic        rw, br;
        logic [1:0]  mem;
        logic        ill;
    } row_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
        bus.d_i_valid   = v;
        bus.d_i_instr   = instr;
        bus.d_i_data_rs = rs;
        bus.d_i_data_rt = rt;
        bus.d_i_pc      = 32'h1000 + instr[7:0];
    endtask

    function automatic logic [165:0] all_outs;
        return {bus.d_o_funct, bus.d_o_alu_src, bus.d_o_imm, bus.d_o_data_rs, bus.d_o_data_rt,
                bus.d_o_pc, bus.d_o_rd, bus.d_o_reg_write, bus.d_o_is_branch, bus.d_o_mem, bus.d_o_illegal};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        bus.d_i_flush = 1'b0;
        bus.d_i_ready = 1'b0;
        repeat (3) tick;
        vec++; if ({bus.d_o_valid, bus.d_o_ready} !== 2'b01) begin errs++; $display("FAIL reset_hs valid/ready=%b%b expected 01", bus.d_o_valid, bus.d_o_ready); end
        vec++; if (all_outs() !== '0) begin errs++; $display("FAIL reset_outs got %h expected 0", all_outs()); end
        rst_n = 1'b1;
        tick;
        vec++; if ({bus.d_o_valid, bus.d_o_ready} !== 2'b01 || all_outs() !== '0) begin errs++; $display("FAIL reset_release valid/ready=%b%b outs=%h expected 01/0", bus.d_o_valid, bus.d_o_ready, all_outs()); end
    endtask

    task automatic test_add;
        bus.d_i_ready = 1'b1;
        drive(1'b1, 32'h00221820, 32'd5, 32'd7);
        tick;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        vec++; if (bus.d_o_valid !== 1'b1) begin errs++; $display("FAIL add_valid got %b expected 1", bus.d_o_valid); end
        vec++; if ({bus.d_o_funct, bus.d_o_alu_src, bus.d_o_rd, bus.d_o_reg_write} !== {5'd0, 1'b0, 5'd3, 1'b1})
            begin errs++; $display("FAIL add_ctrl funct=%0d src=%b rd=%0d rw=%b expected 0/0/3/1", bus.d_o_funct, bus.d_o_alu_src, bus.d_o_rd, bus.d_o_reg_write); end
        vec++; if ({bus.d_o_data_rs, bus.d_o_data_rt, bus.d_o_pc} !== {32'd5, 32'd7, 32'h1020})
            begin errs++; $display("FAIL add_data rs=%h rt=%h pc=%h expected 5/7/1020", bus.d_o_data_rs, bus.d_o_data_rt, bus.d_o_pc); end
        tick;
        vec++; if (bus.d_o_valid !== 1'b0) begin errs++; $display("FAIL add_drain valid=%b expected 0", bus.d_o_valid); end
    endtask

    task automatic test_ori_sll;
        logic [31:0] res;
        drive(1'b1, 32'h34048001, 32'h0, 32'hDEADBEEF);
        tick;
        vec++; if ({bus.d_o_alu_src, bus.d_o_data_rt, bus.d_o_funct, bus.d_o_rd} !== {1'b0, 32'h00008001, 5'd3, 5'd4})
            begin errs++; $display("FAIL ori src=%b rt=%h funct=%0d rd=%0d expected 0/00008001/3/4", bus.d_o_alu_src, bus.d_o_data_rt, bus.d_o_funct, bus.d_o_rd); end
        drive(1'b1, 32'h00062900, 32'h99, 32'h11);
        tick;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        vec++; if ({bus.d_o_data_rs, bus.d_o_alu_src, bus.d_o_imm, bus.d_o_funct, bus.d_o_rd} !== {32'h11, 1'b1, 16'd4, 5'd7, 5'd5})
            begin errs++; $display("FAIL sll rs=%h src=%b imm=%h funct=%0d rd=%0d expected 11/1/4/7/5", bus.d_o_data_rs, bus.d_o_alu_src, bus.d_o_imm, bus.d_o_funct, bus.d_o_rd); end
        res = bus.d_o_alu_src ? (bus.d_o_data_rs << bus.d_o_imm[4:0]) : (bus.d_o_data_rs << bus.d_o_data_rt[4:0]);
        vec++; if (res !== 32'h110) begin errs++; $display("FAIL sll_alu result=%h expected 00000110", res); end
        tick;
    endtask

    task automatic test_decode_table;
        row_t t [14];
        t[0]  = '{32'h8C220008, 32'h10, 32'h20, 5'd0,  1'b1, 5'd2, 1'b1, 1'b0, 2'b01, 1'b0};
        t[1]  = '{32'hAC220004, 32'h10, 32'h20, 5'd0,  1'b1, 5'd2, 1'b0, 1'b0, 2'b10, 1'b0};
        t[2]  = '{32'h10220003, 32'h10, 32'h20, 5'd10, 1'b0, 5'd2, 1'b0, 1'b1, 2'b00, 1'b0};
        t[3]  = '{32'h14220003, 32'h10, 32'h20, 5'd11, 1'b0, 5'd2, 1'b0, 1'b1, 2'b00, 1'b0};
        t[4]  = '{32'h03E00008, 32'h10, 32'h20, 5'd19, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0};
        t[5]  = '{32'h00221822, 32'h10, 32'h20, 5'd1,  1'b0, 5'd3, 1'b1, 1'b0, 2'b00, 1'b0};
        t[6]  = '{32'h0022182A, 32'h10, 32'h20, 5'd5,  1'b0, 5'd3, 1'b1, 1'b0, 2'b00, 1'b0};
        t[7]  = '{32'h0022182B, 32'h10, 32'h20, 5'd6,  1'b0, 5'd3, 1'b1, 1'b0, 2'b00, 1'b0};
        t[8]  = '{32'h00221827, 32'h10, 32'h20, 5'd4,  1'b0, 5'd3, 1'b1, 1'b0, 2'b00, 1'b0};
        t[9]  = '{32'h00221807, 32'h20, 32'h10, 5'd9,  1'b0, 5'd3, 1'b1, 1'b0, 2'b00, 1'b0};
        t[10] = '{32'h3025F0F0, 32'h10, 32'h0000F0F0, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0, 2'b00, 1'b0};
        t[11] = '{32'h3C071234, 32'h10, 32'h20, 5'd18, 1'b1, 5'd7, 1'b1, 1'b0, 2'b00, 1'b0};
        t[12] = '{32'h2427FFFF, 32'h10, 32'h20, 5'd14, 1'b1, 5'd7, 1'b1, 1'b0, 2'b00, 1'b0};
        t[13] = '{32'hFC000000, 32'h10, 32'h20, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1};
        bus.d_i_ready = 1'b1;
        // Back-to-back pushes with ready high: the slot advances every cycle.
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, t[i].instr, 32'h10, 32'h20);
            tick;
            vec++;
            if ({bus.d_o_valid, bus.d_o_funct, bus.d_o_alu_src, bus.d_o_reg_write, bus.d_o_is_branch, bus.d_o_mem, bus.d_o_illegal,
                 bus.d_o_data_rs, bus.d_o_data_rt} !== {1'b1, t[i].funct, t[i].src, t[i].rw, t[i].br, t[i].mem, t[i].ill, t[i].ds, t[i].dt} ||
                (!t[i].ill && bus.d_o_rd !== t[i].rd))
                begin errs++; $display("FAIL decode[%0d] instr=%h v=%b funct=%0d src=%b rw=%b br=%b mem=%b ill=%b rd=%0d rs=%h rt=%h expected funct=%0d src=%b rw=%b br=%b mem=%b ill=%b rd=%0d rs=%h rt=%h",
                    i, t[i].instr, bus.d_o_valid, bus.d_o_funct, bus.d_o_alu_src, bus.d_o_reg_write, bus.d_o_is_branch, bus.d_o_mem, bus.d_o_illegal, bus.d_o_rd, bus.d_o_data_rs, bus.d_o_data_rt,
                    t[i].funct, t[i].src, t[i].rw, t[i].br, t[i].mem, t[i].ill, t[i].rd, t[i].ds, t[i].dt); end
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        tick;
    endtask

    task automatic test_backpressure;
        bus.d_i_ready = 1'b0;
        drive(1'b1, 32'h20010001, 32'h0, 32'h0);
        tick;
        vec++; if ({bus.d_o_valid, bus.d_o_ready, bus.d_o_imm} !== {2'b11, 16'd1}) begin errs++; $display("FAIL bp_first v/r=%b%b imm=%h expected 11/0001", bus.d_o_valid, bus.d_o_ready, bus.d_o_imm); end
        drive(1'b1, 32'h20010002, 32'h0, 32'h0);
        tick;
        vec++; if ({bus.d_o_valid, bus.d_o_ready, bus.d_o_imm} !== {2'b10, 16'd1}) begin errs++; $display("FAIL bp_full v/r=%b%b imm=%h expected 10/0001", bus.d_o_valid, bus.d_o_ready, bus.d_o_imm); end
        drive(1'b1, 32'h20010003, 32'h0, 32'h0);
        tick;
        vec++; if ({bus.d_o_valid, bus.d_o_ready, bus.d_o_imm} !== {2'b10, 16'd1}) begin errs++; $display("FAIL bp_hold v/r=%b%b imm=%h expected 10/0001", bus.d_o_valid, bus.d_o_ready, bus.d_o_imm); end
        bus.d_i_ready = 1'b1;
        tick;
        vec++; if ({bus.d_o_valid, bus.d_o_ready, bus.d_o_imm} !== {2'b11, 16'd2}) begin errs++; $display("FAIL bp_drain1 v/r=%b%b imm=%h expected 11/0002", bus.d_o_valid, bus.d_o_ready, bus.d_o_imm); end
        tick;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        vec++; if ({bus.d_o_valid, bus.d_o_ready, bus.d_o_imm} !== {2'b11, 16'd3}) begin errs++; $display("FAIL bp_drain2 v/r=%b%b imm=%h expected 11/0003", bus.d_o_valid, bus.d_o_ready, bus.d_o_imm); end
        tick;
        vec++; if ({bus.d_o_valid, bus.d_o_ready} !== 2'b01) begin errs++; $display("FAIL bp_empty v/r=%b%b expected 01", bus.d_o_valid, bus.d_o_ready); end
    endtask

    task automatic test_flush;
        bus.d_i_ready = 1'b0;
        drive(1'b1, 32'h20010011, 32'h0, 32'h0); tick;
        drive(1'b1, 32'h20010012, 32'h0, 32'h0); tick;
        drive(1'b1, 32'h20010013, 32'h0, 32'h0);
        bus.d_i_flush = 1'b1;
        tick;
        bus.d_i_flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        vec++; if ({bus.d_o_valid, bus.d_o_ready} !== 2'b01) begin errs++; $display("FAIL flush_full v/r=%b%b expected 01", bus.d_o_valid, bus.d_o_ready); end
        bus.d_i_ready = 1'b1;
        tick; tick;
        vec++; if (bus.d_o_valid !== 1'b0) begin errs++; $display("FAIL flush_ghost valid=%b imm=%h expected 0", bus.d_o_valid, bus.d_o_imm); end
        bus.d_i_ready = 1'b0;
        drive(1'b1, 32'h20010021, 32'h0, 32'h0); tick;
        drive(1'b1, 32'h20010022, 32'h0, 32'h0);
        bus.d_i_flush = 1'b1;
        tick;
        bus.d_i_flush = 1'b0;
        vec++; if ({bus.d_o_valid, bus.d_o_ready} !== 2'b01) begin errs++; $display("FAIL flush_push v/r=%b%b expected 01", bus.d_o_valid, bus.d_o_ready); end
        drive(1'b1, 32'h20010023, 32'h0, 32'h0);
        tick;
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        vec++; if ({bus.d_o_valid, bus.d_o_imm} !== {1'b1, 16'h0023}) begin errs++; $display("FAIL flush_after v=%b imm=%h expected 1/0023", bus.d_o_valid, bus.d_o_imm); end
        bus.d_i_ready = 1'b1;
        tick;
        vec++; if (bus.d_o_valid !== 1'b0) begin errs++; $display("FAIL flush_after_drain valid=%b expected 0", bus.d_o_valid); end
    endtask

    task automatic test_reset_mid;
        bus.d_i_ready = 1'b0;
        drive(1'b1, 32'h20010031, 32'h5, 32'h6); tick;
        drive(1'b1, 32'h20010032, 32'h5, 32'h6);
        #2 rst_n = 1'b0;
        #1;
        vec++; if ({bus.d_o_valid, bus.d_o_ready} !== 2'b01 || all_outs() !== '0) begin errs++; $display("FAIL reset_mid v/r=%b%b outs=%h expected 01/0", bus.d_o_valid, bus.d_o_ready, all_outs()); end
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        tick;
        rst_n = 1'b1;
        tick;
        vec++; if ({bus.d_o_valid, bus.d_o_ready} !== 2'b01 || all_outs() !== '0) begin errs++; $display("FAIL reset_mid_release v/r=%b%b outs=%h expected 01/0", bus.d_o_valid, bus.d_o_ready, all_outs()); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_ori_sll;
        test_decode_table;
        test_backpressure;
        test_flush;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
